// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI receiver slice.
//   state_t         - receiver FSM states
//   DEF_DATA_WIDTH  - default bits per word
//   DEF_CS_POLAR    - default cs_n level while deselected
//   DEF_SAMPLE_RISE - default sampling edge (1 = rising sck)
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam bit DEF_CS_POLAR    = 1'b1;
  localparam bit DEF_SAMPLE_RISE = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: two-flop synchronizer bank for asynchronous inputs.
// Ports:
//   clk   - destination clock
//   a_rst - asynchronous active-high reset (loads rst_val)
//   s_rst - synchronous active-high reset (loads rst_val)
//   d     - asynchronous inputs
//   q     - synchronized outputs, two clk cycles of latency
module spi_sync #(
  parameter int               width   = 1,
  parameter logic [width-1:0] rst_val = '0
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             s_rst,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] meta_p1;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      meta_p1 <= rst_val;
      q       <= rst_val;
    end else if (s_rst) begin
      meta_p1 <= rst_val;
      q       <= rst_val;
    end else begin
      // stage 1 -> stage 2
      meta_p1 <= d;
      q       <= meta_p1;
    end
  end

endmodule

// File: rtl/spi_receiver.sv
// spi_receiver: SPI slave receive path clocked entirely by clk.
// sck, cs_n and mosi are oversampled (f_clk >= 4 * f_sck), edges of sck are
// detected in the clk domain and shifted MSB first into a word that is
// presented on a valid/ready interface.
// Ports:
//   clk, a_rst, s_rst - system clock, async reset, sync reset (active-high)
//   sck, cs_n, mosi   - raw SPI pins, asynchronous to clk
//   data, valid       - received word and its "unconsumed" flag
//   ready             - downstream accepts the word when valid && ready
//   busy              - synchronized chip-select active, delayed
//   overrun           - one-cycle pulse: completed word dropped (valid && !ready)
//   frame_err         - one-cycle pulse: chip select released mid-word
module spi_receiver
  import spi_pkg::*;
#(
  parameter int p_data_width  = DEF_DATA_WIDTH,
  parameter bit p_cs_polar    = DEF_CS_POLAR,
  parameter bit p_sample_rise = DEF_SAMPLE_RISE
) (
  input  logic                    clk,
  input  logic                    a_rst,
  input  logic                    s_rst,
  input  logic                    sck,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic [p_data_width-1:0] data,
  output logic                    valid,
  input  logic                    ready,
  output logic                    busy,
  output logic                    overrun,
  output logic                    frame_err
);

  localparam int                CNT_W   = $clog2(p_data_width) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_data_width);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(p_data_width - 1);

  logic                    sck_p2, cs_n_p2, mosi_p2;
  logic                    sck_p3, cs_act_p3;
  logic                    cs_act, sample_edge;
  logic [CNT_W-1:0]        bit_cnt;
  logic [p_data_width-1:0] shift_q;
  state_t                  state;

  // Synchronizers reset to the idle pin levels so no edge or select is seen
  // while coming out of reset.
  spi_sync #(
    .width   (3),
    .rst_val ({~p_sample_rise, p_cs_polar, 1'b0})
  ) u_sync (
    .clk   (clk),
    .a_rst (a_rst),
    .s_rst (s_rst),
    .d     ({sck, cs_n, mosi}),
    .q     ({sck_p2, cs_n_p2, mosi_p2})
  );

  assign cs_act = (cs_n_p2 == ~p_cs_polar);

  // An sck edge only counts while select has been stable-active for two
  // cycles; this masks sck activity around select transitions.
  assign sample_edge = cs_act && cs_act_p3 &&
                       (p_sample_rise ? (sck_p2 && !sck_p3) : (!sck_p2 && sck_p3));

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      sck_p3    <= ~p_sample_rise;
      cs_act_p3 <= 1'b0;
      busy      <= 1'b0;
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_q   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else if (s_rst) begin
      sck_p3    <= ~p_sample_rise;
      cs_act_p3 <= 1'b0;
      busy      <= 1'b0;
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_q   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // history stage (edge detect) -> busy stage
      sck_p3    <= sck_p2;
      cs_act_p3 <= cs_act;
      busy      <= cs_act_p3;
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      if (valid && ready)
        valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cs_act)
            state <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (!cs_act) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            if (bit_cnt != '0)
              frame_err <= 1'b1;
          end else if (sample_edge) begin
            shift_q <= {shift_q[p_data_width-2:0], mosi_p2};
            if (bit_cnt == CNT_PEN) begin
              bit_cnt <= CNT_LAST;
              state   <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ST_DONE: begin
          // Clearing here lets the next word of the same frame start at once.
          bit_cnt <= '0;
          // A word accepted in this same cycle frees the slot for the new one.
          if (!valid || ready) begin
            data  <= shift_q;
            valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= cs_act ? ST_SHIFT : ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_receiver.sv
// tb_spi_receiver: randomized and directed stimulus for spi_receiver with a
// cycle-scheduled behavioural model of the output interface.
module tb_spi_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, s_rst, sck, cs_n, mosi;
  logic       ready = 1'b1;
  logic       valid, busy, overrun, frame_err;
  logic [7:0] data;

  logic       sck2, cs2_n, mosi2;
  logic       ready2 = 1'b0;
  logic       valid2, busy2, overrun2, frame_err2;
  logic [7:0] data2;

  spi_receiver dut (
    .clk(clk), .a_rst(a_rst), .s_rst(s_rst), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .data(data), .valid(valid), .ready(ready), .busy(busy),
    .overrun(overrun), .frame_err(frame_err)
  );

  spi_receiver #(.p_data_width(8), .p_cs_polar(1'b0), .p_sample_rise(1'b0)) dut2 (
    .clk(clk), .a_rst(a_rst), .s_rst(s_rst), .sck(sck2), .cs_n(cs2_n), .mosi(mosi2),
    .data(data2), .valid(valid2), .ready(ready2), .busy(busy2),
    .overrun(overrun2), .frame_err(frame_err2)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;
  int rdy_mode = 0;

  // Model: events are keyed by the clk edge number at which they must appear.
  logic [7:0] word_at [int];
  bit         ferr_at [int];
  bit         busy_at [int];
  bit         valid_m = 1'b0;
  logic [7:0] data_m  = 8'h00;
  bit         ov_m    = 1'b0;
  bit         fe_m    = 1'b0;
  bit         busy_m  = 1'b0;
  int         bitcnt  = 0;
  logic [7:0] shreg   = 8'h00;

  logic [7:0] got_q [$];
  int n_ov = 0, n_fe = 0, n_vcyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] gq(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'hxx;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (a_rst || s_rst) begin
      valid_m = 1'b0; data_m = 8'h00; ov_m = 1'b0; fe_m = 1'b0; busy_m = 1'b0;
      word_at.delete(); ferr_at.delete(); busy_at.delete();
    end else begin
      ov_m = 1'b0;
      fe_m = ferr_at.exists(cyc);
      if (busy_at.exists(cyc)) busy_m = busy_at[cyc];
      if (word_at.exists(cyc)) begin
        if (!valid_m || ready) begin
          data_m  = word_at[cyc];
          valid_m = 1'b1;
        end else begin
          ov_m = 1'b1;
        end
      end else if (valid_m && ready) begin
        valid_m = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("valid", {31'd0, valid}, {31'd0, valid_m});
      chk("data", {24'd0, data}, {24'd0, data_m});
      chk("overrun", {31'd0, overrun}, {31'd0, ov_m});
      chk("frame_err", {31'd0, frame_err}, {31'd0, fe_m});
      chk("busy", {31'd0, busy}, {31'd0, busy_m});
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (valid && ready) got_q.push_back(data);
    if (overrun) n_ov++;
    if (frame_err) n_fe++;
    if (valid) n_vcyc++;
  end

  initial forever begin
    @(negedge clk);
    #1;
    case (rdy_mode)
      0:       ready = 1'b1;
      1:       ready = 1'b0;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Pin change now is first registered at edge cyc+1: select visible to the
  // FSM after cyc+2, frame error flagged at cyc+3, busy follows at cyc+4.
  task automatic cs_drive(input bit d2, input bit act);
    if (d2) begin
      cs2_n = act;
    end else begin
      cs_n = ~act;
      busy_at[cyc + 4] = act;
      if (!act && bitcnt != 0) ferr_at[cyc + 3] = 1'b1;
      if (!act) bitcnt = 0;
    end
  endtask

  task automatic send_bits(input bit d2, input logic [7:0] w, input int nb);
    logic [7:0] wv;
    wv = w;
    for (int i = 0; i < nb; i++) begin
      if (d2) mosi2 = wv[7-i]; else mosi = wv[7-i];
      tick($urandom_range(2, 4));
      if (d2) begin
        sck2 = 1'b0;
      end else begin
        sck   = 1'b1;
        shreg = {shreg[6:0], wv[7-i]};
        bitcnt++;
        if (bitcnt == 8) begin
          word_at[cyc + 4] = shreg;
          bitcnt = 0;
        end
      end
      tick($urandom_range(2, 4));
      if (d2) sck2 = 1'b1; else sck = 1'b0;
    end
  endtask

  task automatic frame(input bit d2, input logic [7:0] w0, input logic [7:0] w1,
                       input int nw, input int xb);
    cs_drive(d2, 1'b1);
    tick($urandom_range(2, 3));
    if (nw > 0) send_bits(d2, w0, 8);
    if (nw > 1) send_bits(d2, w1, 8);
    if (xb > 0) send_bits(d2, 8'($urandom), xb);
    tick($urandom_range(1, 3));
    cs_drive(d2, 1'b0);
    tick($urandom_range(3, 5));
  endtask

  task automatic clr();
    got_q.delete();
    n_ov = 0; n_fe = 0; n_vcyc = 0;
  endtask

  initial begin
    a_rst = 1'b1; s_rst = 1'b0;
    cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    cs2_n = 1'b0; sck2 = 1'b1; mosi2 = 1'b0;
    tick(4);
    a_rst = 1'b0;
    tick(2);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk_en = 1'b1;

    // single word, always ready
    clr(); rdy_mode = 0;
    frame(1'b0, 8'hA5, 8'h00, 1, 0); tick(6);
    chk("a5_count", got_q.size(), 1);
    chk("a5_word", {24'd0, gq(0)}, 32'h A5);
    chk("a5_valid_cycles", n_vcyc, 1);
    chk("a5_errs", n_ov + n_fe, 0);
    chk("a5_model", {24'd0, data_m}, 32'h A5);

    // two words in one select
    clr();
    frame(1'b0, 8'h3C, 8'hC3, 2, 0); tick(6);
    chk("pair_count", got_q.size(), 2);
    chk("pair_w0", {24'd0, gq(0)}, 32'h3C);
    chk("pair_w1", {24'd0, gq(1)}, 32'hC3);

    // second word dropped while the first is held
    clr(); rdy_mode = 1;
    frame(1'b0, 8'h11, 8'h22, 2, 0); tick(4);
    chk("ovr_pulses", n_ov, 1);
    chk("ovr_data", {24'd0, data}, 32'h11);
    chk("ovr_valid", {31'd0, valid}, 32'd1);
    rdy_mode = 0; tick(4);
    chk("ovr_drain", {24'd0, gq(0)}, 32'h11);
    chk("ovr_drain_count", got_q.size(), 1);

    // select released after 5 bits, then a clean frame
    clr();
    frame(1'b0, 8'h00, 8'h00, 0, 5);
    frame(1'b0, 8'h5A, 8'h00, 1, 0); tick(6);
    chk("ferr_pulses", n_fe, 1);
    chk("ferr_next", {24'd0, gq(0)}, 32'h5A);

    // asynchronous reset in the middle of a word
    clr();
    cs_drive(1'b0, 1'b1); tick(3);
    send_bits(1'b0, 8'hF0, 4); tick(1);
    a_rst = 1'b1; tick(1);
    chk("arst_data", {24'd0, data}, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_pulses", {30'd0, overrun, frame_err}, 32'd0);
    cs_n = 1'b1; bitcnt = 0;
    tick(3); a_rst = 1'b0; tick(4);
    frame(1'b0, 8'h81, 8'h00, 1, 0); tick(6);
    chk("arst_after", {24'd0, gq(0)}, 32'h81);
    chk("arst_after_err", n_fe + n_ov, 0);

    // synchronous reset drops a held word
    rdy_mode = 1;
    frame(1'b0, 8'h4D, 8'h00, 1, 0); tick(6);
    chk("srst_pre_valid", {31'd0, valid}, 32'd1);
    s_rst = 1'b1; tick(1); s_rst = 1'b0;
    chk("srst_valid", {31'd0, valid}, 32'd0);
    chk("srst_data", {24'd0, data}, 32'd0);
    rdy_mode = 0; tick(2);

    // inverted select polarity, falling-edge sampling
    begin
      int t;
      frame(1'b1, 8'h96, 8'h00, 1, 0);
      t = 0;
      while (!valid2 && t < 40) begin tick(1); t++; end
      chk("pol_valid", {31'd0, valid2}, 32'd1);
      chk("pol_data", {24'd0, data2}, 32'h96);
      chk("pol_quiet", {29'd0, busy2, overrun2, frame_err2}, 32'd0);
    end

    // randomized frames and back-pressure
    for (int f = 0; f < 40; f++) begin
      rdy_mode = $urandom_range(0, 2);
      frame(1'b0, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
    end
    rdy_mode = 0;
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
